sddr_phy_responder: RTL

//  Cycle-level DDR3 device responder for the PHY-side command/data interface driven by sddr_ctrl.

---
 rtl/sddr_pkg.sv | 28 ++
 rtl/sddr_burst_pipe.sv | 79 +++++++
 rtl/sddr_phy_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sddr_pkg.sv
// Shared command encodings and error-flag bit positions for the DDR3 device responder.
package sddr_pkg;

  typedef enum logic [3:0] {
    CMD_MRS = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_NOP = 4'b0111
  } cmd_e;

  localparam int ERR_ACT_OPEN  = 0;
  localparam int ERR_RW_CLOSED = 1;
  localparam int ERR_TRCD      = 2;
  localparam int ERR_COLLISION = 3;
  localparam int ERR_REF_OPEN  = 4;
  localparam int ERR_TRFC      = 5;

  // BL8 on a DDR pair interface is four clocks of data
  localparam int BURST_LEN = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sddr_burst_pipe.sv
// Delays a burst start by DEPTH clocks, then emits BURST_LEN consecutive beat indices.
module sddr_burst_pipe
  import sddr_pkg::*;
#(
  parameter int DEPTH    = 5,
  parameter int IDX_BITS = 10,
  parameter int TAG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [IDX_BITS-3:0] base_i,
  input  logic [TAG_BITS-1:0] tag_i,
  output logic                beat_valid_o,
  output logic [IDX_BITS-1:0] beat_idx_o,
  output logic                beat_last_o,
  output logic [TAG_BITS-1:0] tag_o
);

  localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [IDX_BITS-3:0] base_q [DEPTH];
  logic [IDX_BITS-3:0] base_d [DEPTH];
  logic [TAG_BITS-1:0] tag_q  [DEPTH];
  logic [TAG_BITS-1:0] tag_d  [DEPTH];
  logic                run_q, run_d;
  logic [1:0]          beat_q, beat_d;
  logic [IDX_BITS-3:0] hold_base_q, hold_base_d;
  logic [TAG_BITS-1:0] hold_tag_q, hold_tag_d;
  logic                head;

  assign head = vld_q[DEPTH-1];

  always_comb begin
    vld_d     = {vld_q[DEPTH-2:0], start_i};
    base_d[0] = base_i;
    tag_d[0]  = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      base_d[i] = base_q[i-1];
      tag_d[i]  = tag_q[i-1];
    end
    run_d       = run_q;
    beat_d      = beat_q;
    hold_base_d = hold_base_q;
    hold_tag_d  = hold_tag_q;
    if (head) begin
      run_d       = 1'b1;
      beat_d      = 2'd1;
      hold_base_d = base_q[DEPTH-1];
      hold_tag_d  = tag_q[DEPTH-1];
    end else if (run_q) begin
      beat_d = beat_q + 2'd1;
      if (beat_q == LAST_BEAT) run_d = 1'b0;
    end
  end

  assign beat_valid_o = head | run_q;
  assign beat_idx_o   = head ? {base_q[DEPTH-1], 2'd0} : {hold_base_q, beat_q};
  assign beat_last_o  = run_q && (beat_q == LAST_BEAT);
  assign tag_o        = head ? tag_q[DEPTH-1] : hold_tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      run_q  <= 1'b0;
      beat_q <= '0;
    end else begin
      vld_q  <= vld_d;
      run_q  <= run_d;
      beat_q <= beat_d;
    end
    base_q      <= base_d;
    tag_q       <= tag_d;
    hold_base_q <= hold_base_d;
    hold_tag_q  <= hold_tag_d;
  end

endmodule

// File: rtl/sddr_phy_responder.sv
// Cycle-level DDR3 device model: command decode, per-bank row tracking, BL8 store/return
// after CWL/CL, and sticky protocol-timing error flags.
module sddr_phy_responder
  import sddr_pkg::*;
#(
  parameter int BANK_BITS = 3,
  parameter int ROW_BITS  = 13,
  parameter int COL_BITS  = 10,
  parameter int DATA_BITS = 16,
  parameter int MEM_BITS  = 10,
  parameter int tRCD      = 5,
  parameter int tRFC      = 20,
  parameter int CL        = 5,
  parameter int CWL       = 5
) (
  input  logic                                      ddr_clock_i,
  input  logic                                      reset_i,
  input  logic                                      cke_i,
  input  logic                                      cs_n_i,
  input  logic                                      ras_n_i,
  input  logic                                      cas_n_i,
  input  logic                                      we_n_i,
  input  logic [BANK_BITS-1:0]                      ba_i,
  input  logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0]   addr_i,
  input  logic [1:0][DATA_BITS-1:0]                 dq_i,
  output logic [1:0][DATA_BITS-1:0]                 dq_o,
  output logic                                      dq_valid_o,
  output logic [7:0]                                error_o,
  output logic [15:0]                               refresh_count_o
);

  localparam int NB        = 2 ** BANK_BITS;
  localparam int BASE_BITS = MEM_BITS - 2;
  localparam int TAG_BITS  = BANK_BITS + 1;
  localparam int FULL_BITS = BANK_BITS + ROW_BITS + COL_BITS - 3;
  localparam logic [2:0] GAP_MIN = 3'(BURST_LEN);

  logic [NB-1:0]           open_q, open_d;
  logic [ROW_BITS-1:0]     row_q [NB];
  logic [ROW_BITS-1:0]     row_d [NB];
  logic [7:0]              act_cnt_q [NB];
  logic [7:0]              act_cnt_d [NB];
  logic [2:0]              rw_gap_q, rw_gap_d;
  logic [7:0]              trfc_q, trfc_d;
  logic [7:0]              err_q, err_d;
  logic [15:0]             rcnt_q, rcnt_d;
  logic [1:0][DATA_BITS-1:0] dq_o_q, dq_o_d;
  logic                    dq_valid_q, dq_valid_d;
  logic [1:0][DATA_BITS-1:0] mem_q [2**MEM_BITS];

  cmd_e                    cmd;
  logic                    cmd_en;
  logic                    rd_start, wr_start;
  logic [FULL_BITS-1:0]    full_idx;
  logic [BASE_BITS-1:0]    base;
  logic [TAG_BITS-1:0]     tag;
  logic                    rd_valid, rd_last, wr_valid, wr_last;
  logic [MEM_BITS-1:0]     rd_idx, wr_idx;
  logic [TAG_BITS-1:0]     rd_tag, wr_tag;

  assign cmd_en   = cke_i & ~cs_n_i;
  assign cmd      = cmd_e'({cs_n_i, ras_n_i, cas_n_i, we_n_i});
  assign full_idx = {ba_i, row_q[ba_i], addr_i[COL_BITS-1:3]};
  assign base     = full_idx[BASE_BITS-1:0];
  assign tag      = {addr_i[10], ba_i};

  always_comb begin
    open_d   = open_q;
    row_d    = row_q;
    rw_gap_d = rw_gap_q;
    trfc_d   = trfc_q;
    err_d    = err_q;
    rcnt_d   = rcnt_q;
    rd_start = 1'b0;
    wr_start = 1'b0;
    for (int b = 0; b < NB; b++) act_cnt_d[b] = sat_inc8(act_cnt_q[b]);
    if (rw_gap_q < GAP_MIN) rw_gap_d = rw_gap_q + 3'd1;
    if (trfc_q != 8'd0) trfc_d = trfc_q - 8'd1;

    // auto-precharge lands on the last beat edge, before this clock's command
    if (rd_last && rd_tag[BANK_BITS]) open_d[rd_tag[BANK_BITS-1:0]] = 1'b0;
    if (wr_last && wr_tag[BANK_BITS]) open_d[wr_tag[BANK_BITS-1:0]] = 1'b0;

    if (cmd_en) begin
      if (trfc_q != 8'd0 && cmd != CMD_NOP) err_d[ERR_TRFC] = 1'b1;
      case (cmd)
        CMD_ACT: begin
          if (open_q[ba_i]) begin
            err_d[ERR_ACT_OPEN] = 1'b1;
          end else begin
            open_d[ba_i]    = 1'b1;
            row_d[ba_i]     = addr_i[ROW_BITS-1:0];
            act_cnt_d[ba_i] = 8'd1;
          end
        end
        CMD_RD, CMD_WR: begin
          if (!open_q[ba_i]) err_d[ERR_RW_CLOSED] = 1'b1;
          if (open_q[ba_i] && act_cnt_q[ba_i] < 8'(tRCD)) err_d[ERR_TRCD] = 1'b1;
          if (rw_gap_q < GAP_MIN) err_d[ERR_COLLISION] = 1'b1;
          if (open_q[ba_i] && rw_gap_q >= GAP_MIN) begin
            rw_gap_d = 3'd1;
            if (cmd == CMD_RD) rd_start = 1'b1;
            else               wr_start = 1'b1;
          end
        end
        CMD_PRE: begin
          if (addr_i[10]) open_d = '0;
          else            open_d[ba_i] = 1'b0;
        end
        CMD_REF: begin
          if (|open_q) begin
            err_d[ERR_REF_OPEN] = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 16'd1;
            trfc_d = 8'(tRFC);
          end
        end
        default: ;
      endcase
    end

    dq_valid_d = rd_valid;
    dq_o_d     = '0;
    if (rd_valid) dq_o_d = (wr_valid && wr_idx == rd_idx) ? dq_i : mem_q[rd_idx];
  end

  sddr_burst_pipe #(.DEPTH(CL), .IDX_BITS(MEM_BITS), .TAG_BITS(TAG_BITS)) u_rd_pipe (
    .clk          (ddr_clock_i),
    .rst          (reset_i),
    .start_i      (rd_start),
    .base_i       (base),
    .tag_i        (tag),
    .beat_valid_o (rd_valid),
    .beat_idx_o   (rd_idx),
    .beat_last_o  (rd_last),
    .tag_o        (rd_tag)
  );

  sddr_burst_pipe #(.DEPTH(CWL), .IDX_BITS(MEM_BITS), .TAG_BITS(TAG_BITS)) u_wr_pipe (
    .clk          (ddr_clock_i),
    .rst          (reset_i),
    .start_i      (wr_start),
    .base_i       (base),
    .tag_i        (tag),
    .beat_valid_o (wr_valid),
    .beat_idx_o   (wr_idx),
    .beat_last_o  (wr_last),
    .tag_o        (wr_tag)
  );

  always_ff @(posedge ddr_clock_i) begin
    if (reset_i) begin
      open_q     <= '0;
      rw_gap_q   <= GAP_MIN;
      trfc_q     <= '0;
      err_q      <= '0;
      rcnt_q     <= '0;
      dq_o_q     <= '0;
      dq_valid_q <= 1'b0;
      for (int b = 0; b < NB; b++) act_cnt_q[b] <= '0;
    end else begin
      open_q     <= open_d;
      rw_gap_q   <= rw_gap_d;
      trfc_q     <= trfc_d;
      err_q      <= err_d;
      rcnt_q     <= rcnt_d;
      dq_o_q     <= dq_o_d;
      dq_valid_q <= dq_valid_d;
      act_cnt_q  <= act_cnt_d;
    end
    row_q <= row_d;
  end

  // store contents survive reset; a reset edge still aborts an in-flight write beat
  always_ff @(posedge ddr_clock_i) begin
    if (wr_valid && !reset_i) mem_q[wr_idx] <= dq_i;
  end

  assign dq_o            = dq_o_q;
  assign dq_valid_o      = dq_valid_q;
  assign error_o         = err_q;
  assign refresh_count_o = rcnt_q;

endmodule
